// File: rtl/axi_lite_ctrl_regs.sv
// AXI4-Lite control/status register bank for the BFS core: four R/W config
// registers, a read-only busy/done status word and a one-cycle start pulse.
module axi_lite_ctrl_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_out,
  output logic                            start_pulse,
  input  logic                            core_done
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int NB = DW / 8;
  localparam int SW = C_S_AXI_ADDR_WIDTH - 2;

  logic                r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic                r_start, r_busy, r_done;
  logic [SW-1:0]       r_aw_slot;
  logic [DW-1:0]       r_wdata, r_rdata;
  logic [NB-1:0]       r_wstrb;
  logic [3:0][DW-1:0]  r_regs;

  logic                w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_start;
  logic [SW-1:0]       w_wslot, w_rslot;
  logic [DW-1:0]       w_wdata, w_rd_data;
  logic [NB-1:0]       w_wstrb;
  logic                w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are gated by reset so every output reads 0 while ARESET is high.
  assign S_AXI_AWREADY = !ARESET && !r_aw_held && !r_bvalid;
  assign S_AXI_WREADY  = !ARESET && !r_w_held  && !r_bvalid;
  assign S_AXI_ARREADY = !ARESET && !r_rvalid;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RRESP   = 2'b00;
  assign reg0_out      = r_regs[0];
  assign reg1_out      = r_regs[1];
  assign reg2_out      = r_regs[2];
  assign reg3_out      = r_regs[3];
  assign start_pulse   = r_start;

  assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign w_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wslot  = r_aw_held ? r_aw_slot : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign w_wdata  = r_w_held  ? r_wdata   : S_AXI_WDATA;
  assign w_wstrb  = r_w_held  ? r_wstrb   : S_AXI_WSTRB;
  assign w_start  = w_commit && (w_wslot == '0) && w_wstrb[0] && w_wdata[0];
  assign w_rslot  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_comb begin
    w_rd_data = '0;
    if (w_rslot < SW'(4))
      w_rd_data = r_regs[w_rslot[1:0]];
    else if (w_rslot == SW'(4))
      w_rd_data = {{(DW-2){1'b0}}, r_done, r_busy};
  end

  // Write channel: AW and W may arrive in either order; commit when both are in.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_aw_slot <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_regs    <= '0;
    end else begin
      if (r_bvalid && S_AXI_BREADY)
        r_bvalid <= 1'b0;
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        if (w_wslot < SW'(4))
          for (int b = 0; b < NB; b++)
            if (w_wstrb[b]) r_regs[w_wslot[1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_slot <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= S_AXI_WDATA;
          r_wstrb  <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Start beats a coincident core_done so a fresh run is never reported done.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= w_start;
      if (w_start) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if (core_done) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
    end else if (r_rvalid && S_AXI_RREADY) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule
